// File: rtl/zrb_uart_frame_rx.sv
// Frame parser behind a UART receiver: SYNC, LEN, payload, CHK; payload is released only after the checksum verifies.
// Optional inter-byte timeout when ZRB_UART_FRAME_TIMEOUT_EN is defined.
module zrb_uart_frame_rx #(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       overrun,
  output logic       busy
);
  localparam int AW = $clog2(MAX_LEN);
  localparam int IW = AW + 1;

  localparam logic [2:0] S_HUNT    = 3'd0;
  localparam logic [2:0] S_LEN     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CHK     = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;

  if ((MAX_LEN < 2) || (MAX_LEN > 256) || ((MAX_LEN & (MAX_LEN - 1)) != 0)) begin : g_bad_max_len
    $error("MAX_LEN must be a power of two in 2..256");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be positive");
  end

  logic [2:0]    state;
  logic [7:0]    mem [MAX_LEN];
  logic [7:0]    len;
  logic [7:0]    acc;
  logic [7:0]    chk_sum;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] rd_nxt;
  logic [8:0]    len_m1;
  logic          hs;
  logic          tmo_fire;

  // 9-bit compare space keeps LEN-1 and the extra index bit aligned for any MAX_LEN.
  assign len_m1  = {1'b0, len} - 9'd1;
  assign chk_sum = acc + in_data;
  assign rd_nxt  = rd_idx + 1'b1;
  assign hs      = out_valid & out_ready;
  assign busy    = (state != S_HUNT);

`ifdef ZRB_UART_FRAME_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] idle_cnt;
  logic          in_frame;

  assign in_frame = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
  assign tmo_fire = in_frame && !in_valid && (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n || !in_frame || in_valid || tmo_fire) idle_cnt <= '0;
    else if (idle_cnt != CW'(TIMEOUT_CYCLES))           idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset_n && state == S_PAYLOAD && in_valid) mem[wr_idx[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_HUNT;
      len       <= '0;
      acc       <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
      overrun   <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      case (state)
        S_HUNT: if (in_valid && in_data == SYNC_BYTE) state <= S_LEN;
        S_LEN: if (in_valid) begin
          len    <= in_data;
          acc    <= in_data;
          wr_idx <= '0;
          if ({1'b0, in_data} > 9'(MAX_LEN)) begin
            frame_err <= 1'b1;
            err_code  <= 2'd1;
            state     <= S_HUNT;
          end else if (in_data == 8'd0) state <= S_CHK;
          else                          state <= S_PAYLOAD;
        end
        S_PAYLOAD: if (in_valid) begin
          acc    <= chk_sum;
          wr_idx <= wr_idx + 1'b1;
          if (9'(wr_idx) == len_m1) state <= S_CHK;
        end
        S_CHK: if (in_valid) begin
          if (chk_sum == 8'd0) begin
            frame_ok <= 1'b1;
            if (len != 8'd0) begin
              // First payload byte is presented together with the frame_ok pulse.
              state     <= S_DRAIN;
              out_valid <= 1'b1;
              out_data  <= mem[0];
              out_last  <= (len == 8'd1);
              rd_idx    <= '0;
            end else state <= S_HUNT;
          end else begin
            frame_err <= 1'b1;
            err_code  <= 2'd2;
            state     <= S_HUNT;
          end
        end
        S_DRAIN: begin
          if (in_valid) overrun <= 1'b1;
          if (hs) begin
            if (out_last) begin
              state     <= S_HUNT;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              rd_idx   <= rd_nxt;
              out_data <= mem[rd_nxt[AW-1:0]];
              out_last <= (9'(rd_nxt) == len_m1);
            end
          end
        end
        default: state <= S_HUNT;
      endcase
      if (tmo_fire) begin
        frame_err <= 1'b1;
        err_code  <= 2'd3;
        state     <= S_HUNT;
      end
    end
  end
endmodule

// File: tb/tb_zrb_uart_frame_rx.sv
// Bench for zrb_uart_frame_rx: byte-level frame model with per-cycle compare, plus directed literal checks.
module tb_zrb_uart_frame_rx;
  localparam int         MAXL = 16;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TO   = 100;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       overrun;
  logic       busy;

  zrb_uart_frame_rx #(.MAX_LEN(MAXL), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: candidate frame bytes, payload awaiting delivery, pending pulses.
  logic [7:0] fb[$];
  logic [7:0] exp_q[$];
  bit         pend_ok, pend_err, pend_ov;
  logic [1:0] m_code;
  int         idle;
  bit         mon_en = 0;
  int         cyc = 0;

  // Observations of the DUT, checked by the directed tests against literals.
  int         ok_cnt = 0, err_cnt = 0, ov_cnt = 0;
  logic [1:0] obs_code;
  logic [7:0] dl_data[$];
  bit         dl_last[$];
  int         dl_cyc[$];

  task automatic model_byte(input logic [7:0] b);
    int sum;
    if (fb.size() == 0) begin
      if (b == SYNC) fb.push_back(b);
    end else begin
      fb.push_back(b);
      if (fb.size() == 2 && int'(b) > MAXL) begin
        pend_err = 1; m_code = 2'd1; fb.delete();
      end else if (fb.size() == int'(fb[1]) + 3) begin
        sum = 0;
        for (int i = 1; i < fb.size(); i++) sum += fb[i];
        if (sum % 256 == 0) begin
          pend_ok = 1;
          for (int i = 2; i < fb.size() - 1; i++) exp_q.push_back(fb[i]);
        end else begin
          pend_err = 1; m_code = 2'd2;
        end
        fb.delete();
      end
    end
  endtask

  always @(negedge clk) begin
    bit draining;
    if (mon_en) begin
      cyc++;
      chk("frame_ok", frame_ok, pend_ok);
      chk("frame_err", frame_err, pend_err);
      chk("overrun", overrun, pend_ov);
      chk("err_code", err_code, m_code);
      chk("busy", busy, (fb.size() > 0 || exp_q.size() > 0));
      chk("out_valid", out_valid, exp_q.size() > 0);
      if (frame_ok) ok_cnt++;
      if (frame_err) begin err_cnt++; obs_code = err_code; end
      if (overrun) ov_cnt++;
      pend_ok = 0; pend_err = 0; pend_ov = 0;
      draining = exp_q.size() > 0;
      if (out_valid && exp_q.size() > 0) begin
        chk("out_data", out_data, exp_q[0]);
        chk("out_last", out_last, exp_q.size() == 1);
        if (out_ready) begin
          dl_data.push_back(out_data); dl_last.push_back(out_last); dl_cyc.push_back(cyc);
          void'(exp_q.pop_front());
        end
      end
      if (!reset_n) begin
        fb.delete(); exp_q.delete(); m_code = 2'd0; idle = 0;
      end else if (in_valid) begin
        idle = 0;
        if (draining) pend_ov = 1;
        else model_byte(in_data);
      end
`ifdef ZRB_UART_FRAME_TIMEOUT_EN
      else if (fb.size() > 0) begin
        idle++;
        if (idle == TO) begin pend_err = 1; m_code = 2'd3; fb.delete(); idle = 0; end
      end
`endif
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1; in_data = b; tick();
    in_valid = 0; tick();
  endtask

  task automatic send(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  int ok0, err0, ov0;
  task automatic snap();
    ok0 = ok_cnt; err0 = err_cnt; ov0 = ov_cnt;
    dl_data.delete(); dl_last.delete(); dl_cyc.delete();
  endtask

  task automatic chk_frame1(input string tag);
    chk({tag, "_n"}, dl_data.size(), 3);
    if (dl_data.size() == 3) begin
      chk({tag, "_b0"}, dl_data[0], 8'h11);
      chk({tag, "_b1"}, dl_data[1], 8'h22);
      chk({tag, "_b2"}, dl_data[2], 8'h33);
      chk({tag, "_last"}, {dl_last[0], dl_last[1], dl_last[2]}, 3'b001);
    end
  endtask

  logic [7:0] frame1[$] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};

  initial begin
    reset_n = 0; in_valid = 0; in_data = 0; out_ready = 1;
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_pulses", {frame_ok, frame_err, overrun, out_last}, 4'b0);
    mon_en = 1; reset_n = 1; tick();

    // 1: good 3-byte frame, consumer always ready
    snap(); send(frame1); repeat (4) tick();
    chk("t1_ok", ok_cnt - ok0, 1);
    chk("t1_err", err_cnt - err0, 0);
    chk_frame1("t1");
    if (dl_cyc.size() == 3) chk("t1_consec", dl_cyc[2] - dl_cyc[0], 2);

    // 2: bad checksum, then 1-byte frame whose payload equals SYNC
    snap(); send('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98}); tick();
    chk("t2_err", err_cnt - err0, 1);
    chk("t2_code", obs_code, 2);
    chk("t2_nodata", dl_data.size(), 0);
    snap(); send('{8'hA5, 8'h01, 8'h5A, 8'hA5}); repeat (3) tick();
    chk("t2_ok", ok_cnt - ok0, 1);
    chk("t2_n", dl_data.size(), 1);
    if (dl_data.size() == 1) begin
      chk("t2_b0", dl_data[0], 8'h5A);
      chk("t2_last", dl_last[0], 1);
    end

    // 3: preamble ignored, LEN too large, then empty frame
    snap(); send('{8'h00, 8'hFF, 8'hA5});
    in_valid = 1; in_data = 8'h11; tick();
    chk("t3_err_pulse", frame_err, 1);
    chk("t3_code", err_code, 1);
    in_valid = 0; tick();
    chk("t3_err", err_cnt - err0, 1);
    snap(); send('{8'hA5, 8'h00, 8'h00}); tick();
    chk("t3_ok", ok_cnt - ok0, 1);
    chk("t3_nodata", dl_data.size(), 0);
    chk("t3_busy", busy, 0);

    // 4: stalled consumer with bytes arriving during drain
    snap(); out_ready = 0; send(frame1);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 3 == 1); in_data = 8'h5A; tick();
    end
    in_valid = 0;
    chk("t4_hold_data", out_data, 8'h11);
    chk("t4_hold_valid", out_valid, 1);
    out_ready = 1; repeat (5) tick();
    chk("t4_ov", ov_cnt - ov0, 3);
    chk("t4_ok", ok_cnt - ok0, 1);
    chk_frame1("t4");

`ifdef ZRB_UART_FRAME_TIMEOUT_EN
    // 5: stalled partial frame times out
    snap(); send('{8'hA5, 8'h02, 8'h11}); repeat (TO + 10) tick();
    chk("t5_err", err_cnt - err0, 1);
    chk("t5_code", obs_code, 3);
    snap(); send(frame1); repeat (4) tick();
    chk_frame1("t5");
`endif

    // 6: reset mid-payload and mid-drain
    snap(); send('{8'hA5, 8'h03, 8'h11});
    reset_n = 0; tick(); reset_n = 1;
    chk("t6a_outs", {out_valid, out_last, frame_ok, frame_err, overrun, busy}, 6'b0);
    chk("t6a_code", err_code, 0);
    tick();
    send(frame1); repeat (4) tick();
    chk("t6a_err", err_cnt - err0, 0);
    chk_frame1("t6a");
    snap(); out_ready = 0; send(frame1); repeat (2) tick();
    reset_n = 0; tick(); reset_n = 1;
    chk("t6b_outs", {out_valid, out_last, frame_ok, frame_err, overrun, busy}, 6'b0);
    chk("t6b_data", out_data, 0);
    out_ready = 1; tick();
    snap(); send(frame1); repeat (4) tick();
    chk("t6b_err", err_cnt - err0, 0);
    chk_frame1("t6b");

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
